// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared constants for the execute stage of the 16-bit pipeline:
//   - ALU opcode values (OP_ADD .. OP_PASSB); 11..31 are reserved
//   - bit positions of Z/N/C/V inside the 4-bit flag vector {Z,N,C,V}
//   - operand forwarding select encodings
//   - execute-stage FSM state type
// ---------------------------------------------------------------------------
package ex_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOT   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_MUL   = 5'd9;
  localparam logic [4:0] OP_PASSB = 5'd10;

  // flag_ex is {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Encoding 3 behaves like FWD_ID (falls to the default arm)
  localparam logic [1:0] FWD_ID = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_DM = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// ---------------------------------------------------------------------------
// ex_mul_seq
// Iterative shift-add multiplier producing the low WIDTH bits of the
// unsigned product, one partial product per clock.
//   clk, reset     : clock, asynchronous active-high reset (aborts a run)
//   start          : load a/b and begin (ignored while busy)
//   a, b           : operands sampled on the start edge
//   busy           : a multiply is in progress
//   done           : this is the last step; product_lo is final now and
//                    busy drops on the coming edge
//   product_lo     : accumulator including the current step's partial product
// ---------------------------------------------------------------------------
module ex_mul_seq #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] acc_next;

  // a shifts left and b shifts right each step, so bit 0 of b_sh always
  // selects whether the current weighted copy of a is added.
  assign acc_next   = acc_reg + (b_sh_reg[0] ? a_sh_reg : '0);
  assign busy       = busy_reg;
  assign done       = busy_reg && (count_reg == CW'(CYCLES - 1));
  assign product_lo = acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (busy_reg) begin
      acc_reg   <= acc_next;
      a_sh_reg  <= a_sh_reg << 1;
      b_sh_reg  <= b_sh_reg >> 1;
      count_reg <= count_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end else if (start) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      acc_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_block.sv
// ---------------------------------------------------------------------------
// ex_block
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply,
// and the EX/DM pipeline register.
//   clk, reset        : clock, asynchronous active-high reset
//   A, B              : operands from decode (B is also store data)
//   imm_in, imm_sel   : immediate and ALU-B select
//   op_dec            : ALU opcode
//   fwd_a_sel/b_sel   : 0/3 = decode value, 1 = ans_ex, 2 = ans_dm
//   ans_dm            : DM-stage result for forwarding
//   mem_*_id          : memory controls from decode
//   ans_ex, DM_data   : registered result/address and store data
//   mem_rw_ex, mem_en_ex, mem_mux_sel_dm : registered memory controls
//   flag_ex           : registered {Z,N,C,V}
//   stall_ex          : decode must hold its instruction
// ---------------------------------------------------------------------------
module ex_block
  import ex_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             imm_sel,
  input  logic [4:0]       op_dec,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] ans_dm,
  input  logic             mem_rw_id,
  input  logic             mem_en_id,
  input  logic             mem_mux_sel_id,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] DM_data,
  output logic             mem_rw_ex,
  output logic             mem_en_ex,
  output logic             mem_mux_sel_dm,
  output logic [3:0]       flag_ex,
  output logic             stall_ex
);

  localparam int SHW = $clog2(WIDTH);

  ex_state_t        state_reg;
  logic [WIDTH-1:0] ans_ex_reg;
  logic [WIDTH-1:0] dm_data_reg;
  logic             mem_rw_reg;
  logic             mem_en_reg;
  logic             mem_mux_reg;
  logic [3:0]       flag_reg;

  // Controls and store data parked while the multiply runs
  logic             cap_rw_reg;
  logic             cap_en_reg;
  logic             cap_mux_reg;
  logic [WIDTH-1:0] cap_data_reg;

  // ---------------- operand forwarding ----------------
  logic [1:0][WIDTH-1:0] fwd_src;
  logic [1:0][1:0]       fwd_sel;
  logic [1:0][WIDTH-1:0] fwd_val;

  assign fwd_src[0] = A;
  assign fwd_src[1] = B;
  assign fwd_sel[0] = fwd_a_sel;
  assign fwd_sel[1] = fwd_b_sel;

  // FWD_EX reads the current (pre-edge) pipeline register value
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_val[gi] = (fwd_sel[gi] == FWD_EX) ? ans_ex_reg :
                         (fwd_sel[gi] == FWD_DM) ? ans_dm     :
                                                   fwd_src[gi];
  end

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;

  assign op_a  = fwd_val[0];
  assign fwd_b = fwd_val[1];
  assign op_b  = imm_sel ? imm_in : fwd_b;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_upd;    // flags written by this op
  logic             alu_legal;  // opcode is defined
  logic [3:0]       alu_flags;
  logic [SHW-1:0]   shamt;

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};
  assign shamt  = op_b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_upd   = 1'b1;
    alu_legal = 1'b1;
    case (op_dec)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];  // borrow out of the 17-bit difference
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOT:   alu_res = ~op_a;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = $signed(op_a) >>> shamt;
      OP_PASSB: begin
        alu_res = op_b;
        alu_upd = 1'b0;
      end
      default: begin
        alu_upd   = 1'b0;
        alu_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_Z] = (alu_res == '0);
    alu_flags[FLG_N] = alu_res[WIDTH-1];
    alu_flags[FLG_C] = alu_c;
    alu_flags[FLG_V] = alu_v;
  end

  // ---------------- multiplier ----------------
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [3:0]       mul_flags;

  assign mul_start = (state_reg == ST_IDLE) && (op_dec == OP_MUL);

  ex_mul_seq #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk        (clk),
    .reset      (reset),
    .start      (mul_start),
    .a          (op_a),
    .b          (op_b),
    .busy       (mul_busy),
    .done       (mul_done),
    .product_lo (mul_product)
  );

  always_comb begin
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_product == '0);
    mul_flags[FLG_N] = mul_product[WIDTH-1];
  end

  // Drops on the last multiply step so decode can present the next
  // instruction for the edge that writes the product.
  assign stall_ex = !reset && (mul_start || (mul_busy && !mul_done));

  // ---------------- FSM + EX/DM pipeline register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      ans_ex_reg   <= '0;
      dm_data_reg  <= '0;
      mem_rw_reg   <= 1'b0;
      mem_en_reg   <= 1'b0;
      mem_mux_reg  <= 1'b0;
      flag_reg     <= '0;
      cap_rw_reg   <= 1'b0;
      cap_en_reg   <= 1'b0;
      cap_mux_reg  <= 1'b0;
      cap_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (op_dec == OP_MUL) begin
            // Issue a bubble; ans_ex and flags hold until the product lands
            state_reg    <= ST_MUL;
            cap_rw_reg   <= mem_rw_id;
            cap_en_reg   <= mem_en_id;
            cap_mux_reg  <= mem_mux_sel_id;
            cap_data_reg <= fwd_b;
            mem_en_reg   <= 1'b0;
            mem_mux_reg  <= 1'b0;
          end else begin
            ans_ex_reg  <= alu_legal ? alu_res : '0;
            dm_data_reg <= fwd_b;
            mem_rw_reg  <= mem_rw_id;
            mem_en_reg  <= alu_legal ? mem_en_id : 1'b0;
            mem_mux_reg <= mem_mux_sel_id;
            if (alu_upd) begin
              flag_reg <= alu_flags;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_reg   <= ST_IDLE;
            ans_ex_reg  <= mul_product;
            flag_reg    <= mul_flags;
            dm_data_reg <= cap_data_reg;
            mem_rw_reg  <= cap_rw_reg;
            mem_en_reg  <= cap_en_reg;
            mem_mux_reg <= cap_mux_reg;
          end else begin
            mem_en_reg  <= 1'b0;
            mem_mux_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ans_ex         = ans_ex_reg;
  assign DM_data        = dm_data_reg;
  assign mem_rw_ex      = mem_rw_reg;
  assign mem_en_ex      = mem_en_reg;
  assign mem_mux_sel_dm = mem_mux_reg;
  assign flag_ex        = flag_reg;

endmodule
